// File: rtl/bs_gnrtr_n_rbtr.sv
// Multi-bus shared-medium interconnect: one round-robin arbiter per bus
// pops a packet from a pending driver and delivers it to its target(s).
module bs_gnrtr_n_rbtr #(
    parameter int         BITS      = 4,
    parameter int         DRVRS     = 4,
    parameter int         PCKG_SZ   = 32,
    parameter logic [7:0] BROADCAST = 8'hFF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pndng  [BITS][DRVRS],
    input  logic [PCKG_SZ-1:0] D_pop  [BITS][DRVRS],
    output logic               pop    [BITS][DRVRS],
    output logic               push   [BITS][DRVRS],
    output logic [PCKG_SZ-1:0] D_push [BITS][DRVRS]
);

    localparam int PW = (DRVRS > 1) ? $clog2(DRVRS) : 1;

    typedef enum logic {IDLE, SEND} state_t;

    for (genvar k = 0; k < BITS; k++) begin : g_bus
        state_t             r_st;
        logic [PW-1:0]      r_ptr;
        logic [PCKG_SZ-1:0] r_data;
        logic [PCKG_SZ-1:0] r_dpush;
        logic [DRVRS-1:0]   r_pop;
        logic [DRVRS-1:0]   r_push;

        logic [DRVRS-1:0]   w_req;
        logic [DRVRS-1:0]   w_dst;
        logic [PW-1:0]      w_gnt;
        logic               w_any;
        logic [7:0]         w_tgt;
        int                 w_dist;
        int                 w_best;

        assign w_tgt = r_data[PCKG_SZ-1 -: 8];

        for (genvar j = 0; j < DRVRS; j++) begin : g_drv
            assign w_req[j]     = pndng[k][j];
            assign pop[k][j]    = r_pop[j];
            assign push[k][j]   = r_push[j];
            assign D_push[k][j] = r_dpush;
            // Broadcast skips the sender; unknown targets match nobody.
            assign w_dst[j] = (w_tgt == BROADCAST) ? (r_ptr != PW'(j))
                                                   : (int'(w_tgt) == j);
        end

        // Distance 0 is the driver just after the last grant.
        always_comb begin
            w_gnt  = r_ptr;
            w_any  = 1'b0;
            w_best = DRVRS;
            w_dist = 0;
            for (int j = 0; j < DRVRS; j++) begin
                w_dist = (j + DRVRS - 1 - int'(r_ptr)) % DRVRS;
                if (w_req[j] && w_dist < w_best) begin
                    w_best = w_dist;
                    w_gnt  = PW'(j);
                    w_any  = 1'b1;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                r_st    <= IDLE;
                r_ptr   <= PW'(DRVRS - 1);
                r_data  <= '0;
                r_dpush <= '0;
                r_pop   <= '0;
                r_push  <= '0;
            end else begin
                unique case (r_st)
                    IDLE: begin
                        r_push <= '0;
                        if (w_any) begin
                            r_pop  <= DRVRS'(1) << w_gnt;
                            r_data <= D_pop[k][w_gnt];
                            r_ptr  <= w_gnt;
                            r_st   <= SEND;
                        end else begin
                            r_pop <= '0;
                        end
                    end
                    SEND: begin
                        r_pop   <= '0;
                        r_push  <= w_dst;
                        r_dpush <= r_data;
                        r_st    <= IDLE;
                    end
                    default: r_st <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bs_gnrtr_n_rbtr.sv
// Scoreboard bench for bs_gnrtr_n_rbtr: queued expected pops/pushes per
// bus, checked by a negedge monitor that also models the driver TX FIFOs.
module tb_bs_gnrtr_n_rbtr;

    localparam int B = 4;
    localparam int D = 4;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         pndng  [B][D];
    logic [W-1:0] D_pop  [B][D];
    logic         pop    [B][D];
    logic         push   [B][D];
    logic [W-1:0] D_push [B][D];

    always #5 clk = ~clk;

    bs_gnrtr_n_rbtr dut (
        .clk    (clk),
        .reset  (reset),
        .pndng  (pndng),
        .D_pop  (D_pop),
        .pop    (pop),
        .push   (push),
        .D_push (D_push)
    );

    typedef struct packed {
        logic [3:0]   m;
        logic [W-1:0] d;
    } ev_t;

    ev_t          ep_q [B][$];
    ev_t          es_q [B][$];
    logic [W-1:0] tx_q [B][D][$];

    int n_chk = 0;
    int n_err = 0;

    task automatic fail(string nm, int k, logic [35:0] a, logic [35:0] e);
        n_err++;
        $display("FAIL %s bus=%0d got=%h exp=%h", nm, k, a, e);
    endtask

    function automatic logic [W-1:0] pk(int t, int s, int k, int id);
        return {8'(t), 8'(s), 4'(k), 12'(id)};
    endfunction

    function automatic bit all_empty();
        for (int k = 0; k < B; k++) begin
            if (ep_q[k].size() != 0 || es_q[k].size() != 0) return 0;
            for (int i = 0; i < D; i++)
                if (tx_q[k][i].size() != 0) return 0;
        end
        return 1;
    endfunction

    // Monitor plus TX FIFO model; inputs change only at negedge.
    always @(negedge clk) begin : mon
        logic [3:0] pm;
        logic [3:0] sm;
        ev_t        e;
        for (int k = 0; k < B; k++) begin
            pm = '0;
            sm = '0;
            for (int i = 0; i < D; i++) begin
                pm[i] = pop[k][i];
                sm[i] = push[k][i];
            end
            if (pm != 0 && sm != 0) begin
                n_chk++;
                fail("pop_push_overlap", k, {pm, 32'h0}, {sm, 32'h0});
            end
            if (pm != 0) begin
                n_chk++;
                if (ep_q[k].size() == 0) begin
                    fail("unexpected_pop", k, {pm, 32'h0}, 36'h0);
                end else begin
                    e = ep_q[k].pop_front();
                    if (e.m != pm)
                        fail("pop_sel", k, {pm, 32'h0}, {e.m, 32'h0});
                end
                for (int i = 0; i < D; i++)
                    if (pm[i] && tx_q[k][i].size() > 0)
                        void'(tx_q[k][i].pop_front());
            end
            if (sm != 0) begin
                n_chk++;
                if (es_q[k].size() == 0) begin
                    fail("unexpected_push", k, {sm, D_push[k][0]}, 36'h0);
                end else begin
                    e = es_q[k].pop_front();
                    if ({sm, D_push[k][0]} != e)
                        fail("push", k, {sm, D_push[k][0]}, e);
                end
                n_chk++;
                for (int i = 1; i < D; i++)
                    if (D_push[k][i] != D_push[k][0])
                        fail("dpush_same", k, {4'(i), D_push[k][i]},
                             {4'(0), D_push[k][0]});
            end
        end
        for (int k = 0; k < B; k++)
            for (int i = 0; i < D; i++) begin
                pndng[k][i] = tx_q[k][i].size() > 0;
                D_pop[k][i] = (tx_q[k][i].size() > 0) ? tx_q[k][i][0] : '0;
            end
    end

    task automatic drain(string nm, int budget);
        int c = 0;
        while (!all_empty() && c < budget) begin
            @(negedge clk);
            c++;
        end
        repeat (3) @(negedge clk);
        n_chk++;
        if (!all_empty())
            fail(nm, -1, 36'(c), 36'(budget));
    endtask

    initial begin : stim
        logic [W-1:0] d;
        logic [W-1:0] d2;
        bit           ok;
        bit           seen;

        reset = 1'b1;
        // Ring traffic loaded up front so every pndng is high during reset.
        for (int k = 0; k < B; k++)
            for (int n = 0; n < 256; n++) begin
                d = pk((n % 4 + 1) % 4, n % 4, k, n / 4);
                tx_q[k][n % 4].push_back(d);
                ep_q[k].push_back({4'(1 << (n % 4)), d});
                es_q[k].push_back({4'(1 << ((n % 4 + 1) % 4)), d});
            end

        repeat (3) begin
            @(negedge clk);
            n_chk++;
            ok = 1;
            for (int k = 0; k < B; k++)
                for (int i = 0; i < D; i++)
                    if (pop[k][i] || push[k][i] || D_push[k][i] != 0)
                        ok = 0;
            if (!ok) fail("reset_zero", -1, 36'h1, 36'h0);
        end
        reset = 1'b0;
        drain("ring_drain", 1200);

        d = pk(0, 3, 2, 12'h5A5);
        tx_q[2][3].push_back(d);
        ep_q[2].push_back({4'b1000, d});
        es_q[2].push_back({4'b0001, d});
        drain("sparse_drain", 50);

        d = pk(8'hFF, 1, 0, 12'h0B1);
        tx_q[0][1].push_back(d);
        ep_q[0].push_back({4'b0010, d});
        es_q[0].push_back({4'b1101, d});
        drain("bcast_drain", 50);

        d  = pk(9, 0, 1, 12'h007);
        d2 = pk(3, 2, 1, 12'h008);
        tx_q[1][0].push_back(d);
        tx_q[1][2].push_back(d2);
        ep_q[1].push_back({4'b0001, d});
        ep_q[1].push_back({4'b0100, d2});
        es_q[1].push_back({4'b1000, d2});
        drain("invalid_drain", 50);

        d = pk(0, 2, 3, 12'h009);
        tx_q[3][2].push_back(d);
        ep_q[3].push_back({4'b0100, d});
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (pop[3][2]) seen = 1;
        end
        n_chk++;
        if (!seen) fail("rst_pop_wait", 3, 36'h0, 36'h1);
        reset = 1'b1;
        repeat (2) begin
            @(negedge clk);
            n_chk++;
            ok = 1;
            for (int i = 0; i < D; i++)
                if (push[3][i]) ok = 0;
            if (!ok) fail("rst_abort_push", 3, 36'h1, 36'h0);
        end
        reset = 1'b0;
        d  = pk(1, 0, 3, 12'h00A);
        d2 = pk(2, 3, 3, 12'h00B);
        tx_q[3][0].push_back(d);
        tx_q[3][3].push_back(d2);
        ep_q[3].push_back({4'b0001, d});
        ep_q[3].push_back({4'b1000, d2});
        es_q[3].push_back({4'b0010, d});
        es_q[3].push_back({4'b0100, d2});
        drain("post_rst_drain", 50);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
